spi_slave_rx_tx: RTL

SPI slave endpoint that sits directly downstream of spi_top. It consumes the master's o_spi_clk, o_spi_mosi and o_spi_cs, and drives the master's i_spi_miso. It oversamples the SPI pins on the system clock, supports all four CPOL/CPHA modes, and exchanges one byte per DATA_W SPI clocks, MSB first. Received bytes go out on an RX strobe; reply bytes come in through a single-entry TX holding register with a ready/strobe handshake.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_rx_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI slave endpoint: captured bus mode, controller states
// and the default word width.
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detect taken
// between the last synchronized sample and the one before it.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI slave endpoint: oversampled pins, all four CPOL/CPHA modes, MSB-first words,
// RX strobe out and a single-entry TX holding register with ready/strobe handshake.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | CS high; MISO low, bit counter cleared, SCLK edges ignored
//   ST_LOAD   | one cycle after CS falls; first word moved into tx_shift
//   ST_ACTIVE | CS low; sampling, driving MISO, reloading at word boundary
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              clockPolarity,
    input  logic              clockPhase,
    input  logic              i_spi_clk,
    input  logic              i_spi_mosi,
    input  logic              i_spi_cs,
    output logic              o_spi_miso,
    input  logic [DATA_W-1:0] i_TX_BYTE,
    input  logic              i_TX_DE,
    output logic              o_TX_READY,
    output logic [DATA_W-1:0] o_RX_BYTE,
    output logic              o_RX_DE,
    output logic              o_TX_UNDERRUN,
    output logic              o_busy
);

    localparam int              CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk  (i_clk),
        .rst_n(rst_n),
        .din  (i_spi_clk),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk  (i_clk),
        .rst_n(rst_n),
        .din  (i_spi_cs),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], i_spi_mosi};
        end
    end
    assign mosi_q = mosi_chain[SYNC_STAGES-1];

    spi_state_t        state;
    spi_mode_t         mode;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] hold;
    logic              tx_ready;
    logic              underrun_pend;

    logic sclk_edge, leading, trailing, sample_edge, drive_edge, reload_now, accept_tx;

    // Leading edge leaves the idle level, so the new synchronized level differs from CPOL.
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign leading     = sclk_edge & (sclk_q != mode.cpol);
    assign trailing    = sclk_edge & (sclk_q == mode.cpol);
    assign sample_edge = mode.cpha ? trailing : leading;
    assign drive_edge  = mode.cpha ? leading : trailing;
    assign reload_now  = (state == ST_LOAD) ||
                         ((state == ST_ACTIVE) && !cs_rise && sample_edge && (cnt == LAST));
    assign accept_tx   = i_TX_DE && (tx_ready || reload_now);

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mode          <= '0;
            cnt           <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            hold          <= '0;
            tx_ready      <= 1'b1;
            underrun_pend <= 1'b0;
            o_spi_miso    <= 1'b0;
            o_RX_BYTE     <= '0;
            o_RX_DE       <= 1'b0;
            o_TX_UNDERRUN <= 1'b0;
        end else begin
            o_RX_DE       <= 1'b0;
            o_TX_UNDERRUN <= 1'b0;

            // Reload consumes the old holding value before a same-cycle write lands.
            if (reload_now) begin
                tx_shift <= tx_ready ? '0 : hold;
            end
            if (accept_tx) begin
                hold     <= i_TX_BYTE;
                tx_ready <= 1'b0;
            end else if (reload_now) begin
                tx_ready <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    o_spi_miso    <= 1'b0;
                    cnt           <= '0;
                    underrun_pend <= 1'b0;
                    if (cs_fall) begin
                        mode  <= '{cpol: clockPolarity, cpha: clockPhase};
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    o_TX_UNDERRUN <= tx_ready;
                    if (!mode.cpha) begin
                        o_spi_miso <= tx_ready ? 1'b0 : hold[DATA_W-1];
                    end
                    state <= cs_rise ? ST_IDLE : ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        rx_shift      <= '0;
                        underrun_pend <= 1'b0;
                        o_spi_miso    <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[DATA_W-2:0], mosi_q};
                            if (cnt == LAST) begin
                                cnt           <= '0;
                                o_RX_BYTE     <= {rx_shift[DATA_W-2:0], mosi_q};
                                o_RX_DE       <= 1'b1;
                                underrun_pend <= tx_ready;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        if (drive_edge) begin
                            o_spi_miso <= tx_shift[LAST - cnt];
                        end
                        // An empty reload is only reported once the next word really starts.
                        if (leading && (cnt == '0) && underrun_pend) begin
                            o_TX_UNDERRUN <= 1'b1;
                            underrun_pend <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_TX_READY = tx_ready;
    assign o_busy     = ~cs_q;

endmodule
